// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and its matching
// receiver.
//   uart_state_e         - frame sequencer states (3-bit encoding)
//   PARITY_*             - values for the PARITY parameter
//   CLKS_PER_BIT_DEFAULT - 100 MHz system clock / 9600 Bd
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam int CLKS_PER_BIT_DEFAULT = 10417;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLKS_PER_BIT-1 and wraps.
//   clk      - system clock
//   rst_n    - synchronous active-low reset
//   clear    - hold the count at 0 (used while the line is idle)
//   tick     - last cycle of the current bit period
//   pre_tick - second-to-last cycle of the bit period, lets a user register
//              a flag that lines up exactly with the final cycle
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clear || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
   end

   assign tick     = (cnt == LAST);
   assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a one-word holding buffer.
//   clk_i   - system clock
//   rst_ni  - synchronous active-low reset, aborts any frame in progress
//   data_i  - word to send (DATA_OFFSET is added on acceptance)
//   valid_i - data_i valid; accepted on an edge where valid_i && ready_o
//   ready_o - holding buffer empty
//   txd_o   - serial line, idle high, LSB first, driven from a flop
//   busy_o  - frame in progress
//   done_o  - one-cycle pulse on the last cycle of the final stop bit
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PARITY_NONE,
   parameter int STOP_BITS    = 1,
   parameter int DATA_OFFSET  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 txd_o,
   output logic                 busy_o,
   output logic                 done_o
);

   generate
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
          PARITY < PARITY_NONE || PARITY > PARITY_EVEN || STOP_BITS < 1 || STOP_BITS > 2)
      begin : g_bad_param
         $error("uart_tx_param: illegal parameter combination");
      end
   endgenerate

   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0]        LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0]        LAST_STOP = IW'(STOP_BITS - 1);
   localparam logic [DATA_BITS-1:0] OFS       = DATA_BITS'(DATA_OFFSET);
   localparam logic                 ODD       = (PARITY == PARITY_ODD);

   uart_state_e          state;
   logic [DATA_BITS-1:0] hold;     // holding buffer
   logic [DATA_BITS-1:0] shreg;    // shifts right, bit 0 is the next data bit
   logic                 par_bit;  // parity captured when the word is loaded
   logic [IW-1:0]        idx;      // data bit index, reused as stop bit index
   logic                 ready_q;  // buffer empty
   logic                 txd_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 tick;
   logic                 pre_tick;

   // Counter is pinned at 0 while idle so START always gets a full period.
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clear    (state == ST_IDLE),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         hold    <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         idx     <= '0;
         ready_q <= 1'b1;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (valid_i && ready_q) begin
            hold    <= data_i + OFS;
            ready_q <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!ready_q) begin
                  shreg   <= hold;
                  par_bit <= (^hold) ^ ODD;
                  ready_q <= 1'b1;
                  txd_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  idx     <= '0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  txd_q <= shreg[0];
                  shreg <= shreg >> 1;
                  idx   <= '0;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (idx == LAST_DATA) begin
                     idx <= '0;
                     if (PARITY != PARITY_NONE) begin
                        txd_q <= par_bit;
                        state <= ST_PARITY;
                     end else begin
                        txd_q <= 1'b1;
                        state <= ST_STOP;
                     end
                  end else begin
                     idx   <= idx + 1'b1;
                     txd_q <= shreg[0];
                     shreg <= shreg >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  txd_q <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Raised one cycle early so the registered pulse covers the last cycle.
               if (pre_tick && idx == LAST_STOP) done_q <= 1'b1;
               if (tick) begin
                  if (idx != LAST_STOP) begin
                     idx <= idx + 1'b1;
                  end else if (!ready_q) begin
                     // Next word waiting: start bit follows with no idle gap.
                     shreg   <= hold;
                     par_bit <= (^hold) ^ ODD;
                     ready_q <= 1'b1;
                     txd_q   <= 1'b0;
                     idx     <= '0;
                     state   <= ST_START;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ready_o = ready_q;
   assign txd_o   = txd_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations sharing a clock/reset.
// The reference model turns every accepted word into a per-cycle list of
// expected {start, busy, done, txd} values built from the frame definition;
// frames queue back-to-back, the line idles high when nothing is queued.
module tb_uart_tx_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] dat;
   logic [3:0] vld;
   logic [3:0] rdy, txd, busy, done;

   always #5 clk = ~clk;

   // 0: 8N1 +0x20, 1: 8E1, 2: 8O1, 3: 7N2 at 2 clocks/bit
   int c_t  [4] = '{4, 4, 4, 2};
   int db_t [4] = '{8, 8, 8, 7};
   int par_t[4] = '{0, 2, 1, 0};
   int sb_t [4] = '{1, 1, 1, 2};
   int ofs_t[4] = '{32, 0, 0, 0};

   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DATA_OFFSET(32)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .data_i(dat), .valid_i(vld[0]),
      .ready_o(rdy[0]), .txd_o(txd[0]), .busy_o(busy[0]), .done_o(done[0]));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DATA_OFFSET(0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .data_i(dat), .valid_i(vld[1]),
      .ready_o(rdy[1]), .txd_o(txd[1]), .busy_o(busy[1]), .done_o(done[1]));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DATA_OFFSET(0)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .data_i(dat), .valid_i(vld[2]),
      .ready_o(rdy[2]), .txd_o(txd[2]), .busy_o(busy[2]), .done_o(done[2]));
   uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DATA_OFFSET(0)) u_d (
      .clk_i(clk), .rst_ni(rst_n), .data_i(dat[6:0]), .valid_i(vld[3]),
      .ready_o(rdy[3]), .txd_o(txd[3]), .busy_o(busy[3]), .done_o(done[3]));

   int         n_vec = 0, n_err = 0;
   int         sel = 0, cyc = 0, fall_cyc = 0, last_len = -1, n_done = 0;
   bit         chk_en = 0, pend = 0, last_acc = 0, busy_prev = 0;
   logic [3:0] exq[$];   // {start, busy, done, txd} per future cycle

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d)", tag, got, exp, sel, cyc);
      end
   endtask

   task automatic push_frame(int w);
      int v, ones, nb;
      int bits[$];
      v = (w + ofs_t[sel]) % (1 << db_t[sel]);
      bits.push_back(0);
      ones = 0;
      for (int i = 0; i < db_t[sel]; i++) begin
         bits.push_back((v >> i) & 1);
         ones += (v >> i) & 1;
      end
      if (par_t[sel] == 2) bits.push_back(ones % 2);
      if (par_t[sel] == 1) bits.push_back(1 - ones % 2);
      for (int s = 0; s < sb_t[sel]; s++) bits.push_back(1);
      nb = bits.size();
      for (int j = 0; j < nb; j++)
         for (int c = 0; c < c_t[sel]; c++)
            exq.push_back({(j == 0 && c == 0), 1'b1, (j == nb-1 && c == c_t[sel]-1), bits[j][0]});
   endtask

   // Compare the selected DUT against the model, then decide what the next
   // edge does (reset clears the model; a valid word on an empty buffer is taken).
   task automatic model_step();
      logic [3:0] e;
      last_acc = 0;
      if (chk_en) begin
         e = (exq.size() != 0) ? exq.pop_front() : 4'b0001;
         if (e[3]) pend = 0;
         chk("txd",   txd[sel],  e[0]);
         chk("done",  done[sel], e[1]);
         chk("busy",  busy[sel], e[2]);
         chk("ready", rdy[sel],  !pend);
         if (busy[sel] && !busy_prev) fall_cyc = cyc;
         if (done[sel]) begin
            n_done++;
            last_len = cyc - fall_cyc + 1;
         end
         busy_prev = busy[sel];
      end
      cyc++;
      if (!rst_n) begin
         exq.delete();
         pend = 0;
      end else if (vld[sel] && !pend) begin
         if (exq.size() == 0) exq.push_back(4'b0001);
         push_frame(int'(dat));
         pend     = 1;
         last_acc = 1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int w);
      bit got = 0;
      dat      = 8'(w);
      vld      = '0;
      vld[sel] = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         tick();
         got = last_acc;
      end
      vld = '0;
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while ((exq.size() != 0 || pend) && i < 2000) begin
         tick();
         i++;
      end
      if (exq.size() != 0 || pend) chk("idle_timeout", 0, 1);
      tick();
   endtask

   task automatic select(int s);
      sel       = s;
      busy_prev = 0;
      last_len  = -1;
      n_done    = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      vld   = '0;
      dat   = '0;
      @(posedge clk);
      #1;
      chk_en = 1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("rst_txd",   txd[i],  1);
         chk("rst_ready", rdy[i],  1);
         chk("rst_busy",  busy[i], 0);
         chk("rst_done",  done[i], 0);
      end
      rst_n = 1'b1;
      tick();

      // 8N1 with +0x20: 0x41 goes out as 0x61, 40-cycle frame
      select(0);
      send('h41);
      wait_idle();
      chk("len_8n1", last_len, 40);
      chk("done_8n1", n_done, 1);

      // back-to-back frames
      select(0);
      send('h55);
      send('hAA);
      wait_idle();
      chk("b2b_done", n_done, 2);

      // backpressure: three words queued behind a running frame
      select(0);
      send('h11);
      send('h22);
      send('h33);
      send('h44);
      wait_idle();
      chk("bp_done", n_done, 4);

      // reset in the middle of the data bits
      select(0);
      send('h5A);
      repeat (10) tick();
      chk("mid_busy", busy[0], 1);
      rst_n = 1'b0;
      tick();
      chk("abort_txd",   txd[0],  1);
      chk("abort_busy",  busy[0], 0);
      chk("abort_ready", rdy[0],  1);
      rst_n = 1'b1;
      repeat (3) tick();

      // parity frames
      select(1);
      send('h03);
      wait_idle();
      chk("len_8e1", last_len, 44);
      select(2);
      send('h03);
      wait_idle();
      chk("len_8o1", last_len, 44);

      // 7 data bits, 2 stop bits, 2 clocks per bit
      select(3);
      send('h7F);
      wait_idle();
      chk("len_7n2", last_len, 20);

      // randomized words and gaps on every configuration
      for (int s = 0; s < 4; s++) begin
         select(s);
         for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 50)) tick();
            else repeat ($urandom_range(0, 3)) tick();
            send($urandom_range(0, (1 << db_t[s]) - 1));
         end
         wait_idle();
         chk("rand_done", n_done, 12);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor of the fixed 8N1 serial transmitter. It drives a UART line with configurable bit period, data width, parity and stop bits. An optional per-byte additive offset is applied to each word. A one-word holding buffer with a valid/ready handshake lets the producer queue the next word during a frame, so frames go back-to-back with no idle gap. It sits between the receive/processing logic and the TXD pin.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600 Bd); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
DATA_OFFSET, 0, constant added to every accepted word, modulo 2^DATA_BITS (0x20 gives the legacy lower-case conversion)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; synchronous, active-low
data_i  in  DATA_BITS  word to send
valid_i  in  1  data_i valid
ready_o  out  1  holding buffer empty; a word is accepted on a clock edge where valid_i && ready_o
txd_o  out  1  serial line; idle high; LSB first
busy_o  out  1  frame in progress (state != IDLE)
done_o  out  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (rst_ni low at a clock edge):
  - txd_o=1, ready_o=1, busy_o=0, done_o=0
  - buffer empty, state IDLE, counters 0
  - reset mid-frame aborts the frame at once: txd_o returns high on that edge and the partial frame is discarded
- Accept:
  - at an accepting edge the buffer stores data_i + DATA_OFFSET, truncated to DATA_BITS
  - ready_o is a registered signal: it equals "buffer empty"
- States: IDLE, START, DATA, PARITY, STOP
  - IDLE -> START when the buffer is full. On that edge the buffer moves to the shift register, the buffer empties, txd_o is registered 0 and busy_o goes to 1.
  - Latency: word accepted at edge k -> txd_o low from edge k+1; ready_o high again from edge k+1.
  - START: txd_o=0 for CLKS_PER_BIT cycles.
  - DATA: bit i (i = 0..DATA_BITS-1) is held for CLKS_PER_BIT cycles each.
  - PARITY: entered only if PARITY != 0. Holds XOR of the shifted word (even parity) or its inverse (odd parity) for CLKS_PER_BIT cycles.
  - STOP: txd_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP:
  - done_o=1 for exactly that last cycle
  - if the buffer is full -> START directly (start bit immediately follows the stop bit, zero idle cycles)
  - otherwise -> IDLE, busy_o=0
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, exactly.
- Bit-period counter:
  - width $clog2(CLKS_PER_BIT)
  - counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit
  - no off-by-one: each bit lasts exactly CLKS_PER_BIT cycles
- Bit index counter: width $clog2(DATA_BITS+1); reset to 0 on each START.
- Simultaneous events:
  - accept on the same edge that the buffer is drained is impossible, because ready_o=0 while full
  - valid_i while ready_o=0 is ignored and data is not captured; the producer must hold valid_i
- txd_o is driven straight from a flop (glitch-free).
- Illegal parameter values are caught by an elaboration-time check ($error).

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE/START/DATA/PARITY/STOP, 3 bits)
  - PARITY_NONE/ODD/EVEN constants
  - default CLKS_PER_BIT constant, reused by the matching receiver
- One natural sub-module, uart_baud_cnt:
  - bit-period counter with clear input and tick output, parametrised by CLKS_PER_BIT
  - shared with the receiver
- Holding buffer and FSM stay in the top module.

Test Plan:
- All scenarios run with CLKS_PER_BIT=4 unless noted.
- Reset: hold rst_ni=0 for 3 cycles -> txd_o=1, ready_o=1, busy_o=0, done_o=0. Reassert reset mid-DATA -> txd_o=1 on the next edge and the FSM is in IDLE.
- 8N1, DATA_OFFSET=0x20, send 0x41:
  - line reads 0, then bits of 0x61 LSB first (1,0,0,0,0,1,1,0), then 1; each bit exactly 4 cycles
  - done_o pulses at cycle 40 after txd_o falls
- 8E1, send 0x03 -> parity bit 0. 8O1, send 0x03 -> parity bit 1. Frame is 44 cycles.
- Back-to-back: queue 0x55 and then 0xAA as soon as ready_o rises -> second start bit immediately follows the first stop bit; busy_o never drops between frames; done_o pulses twice.
- Backpressure: hold valid_i with 3 words while a frame is in progress -> ready_o stays 0 until the buffer drains, and all 3 words appear on the line in order with no loss or duplication.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=2, send 0x7F -> frame is 20 cycles with a 4-cycle high stop period.
